// File: rtl/io_bridge.sv
`timescale 1ns/1ps
// Byte-bus bridge between the CPU core, the block RAM and the UART/timer/stop
// I/O window at 0x30000-0x30007.
module io_bridge #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    output logic [16:0] ram_a,
    output logic        ram_we,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        rx_overflow,
    output logic        program_done
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_ONE = 1;
    localparam logic [RAW:0] RX_ONE = 1;

    logic [7:0]  r_tx_mem [TX_DEPTH];
    logic [7:0]  r_rx_mem [RX_DEPTH];
    logic [TAW:0] r_tx_wp, r_tx_rp;
    logic [RAW:0] r_rx_wp, r_rx_rp;
    logic [31:0] r_cnt, r_snap;
    logic        r_io_q, r_rd0_q, r_stop, r_done, r_ovf;
    logic [7:0]  r_io_data;

    logic        w_io, w_io_hit, w_rd, w_wr, w_rd0, w_snap, w_stop_wr;
    logic        w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
    logic        w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
    logic [2:0]  w_off;
    logic [7:0]  w_io_rdata;
    logic        w_unused_a;

    assign w_unused_a = ^cpu_a[31:18];

    assign w_io     = (cpu_a[17:16] == 2'b11);
    assign w_io_hit = w_io && (cpu_a[15:3] == 13'd0);
    assign w_off    = cpu_a[2:0];
    assign w_rd     = cpu_rdy & ~cpu_wr;
    assign w_wr     = cpu_rdy & cpu_wr;

    assign ram_a    = cpu_a[16:0];
    assign ram_dout = cpu_dout;
    assign ram_we   = cpu_wr & ~w_io & cpu_rdy;

    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[TAW] != r_tx_rp[TAW]) && (r_tx_wp[TAW-1:0] == r_tx_rp[TAW-1:0]);
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[RAW] != r_rx_rp[RAW]) && (r_rx_wp[RAW-1:0] == r_rx_rp[RAW-1:0]);

    assign cpu_rdy       = ~w_tx_full;
    assign uart_tx_valid = ~w_tx_empty;
    assign uart_tx_data  = r_tx_mem[r_tx_rp[TAW-1:0]];

    assign w_tx_push = w_wr & w_io_hit & (w_off == 3'd0) & (cpu_dout != 8'h00);
    assign w_tx_pop  = uart_tx_valid & uart_tx_ready;
    assign w_stop_wr = w_wr & w_io_hit & (w_off == 3'd4);
    assign w_snap    = w_rd & w_io_hit & (w_off == 3'd4);

    // A held read of 0x30000 pops only on the first cycle of the run.
    assign w_rd0     = w_rd & w_io_hit & (w_off == 3'd0);
    assign w_rx_pop  = w_rd0 & ~r_rd0_q & ~w_rx_empty;
    assign w_rx_push = uart_rx_valid & (~w_rx_full | w_rx_pop);

    always_comb begin
        w_io_rdata = '0;
        if (w_io_hit) begin
            case (w_off)
                3'd0:    w_io_rdata = w_rx_pop ? r_rx_mem[r_rx_rp[RAW-1:0]] : 8'h00;
                3'd4:    w_io_rdata = r_cnt[7:0];
                3'd5:    w_io_rdata = r_snap[15:8];
                3'd6:    w_io_rdata = r_snap[23:16];
                3'd7:    w_io_rdata = r_snap[31:24];
                default: w_io_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[TAW-1:0]] <= cpu_dout;
        if (w_rx_push) r_rx_mem[r_rx_wp[RAW-1:0]] <= uart_rx_data;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + TX_ONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_ONE;
            if (w_rx_push) r_rx_wp <= r_rx_wp + RX_ONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_ONE;
            if (uart_rx_valid & ~w_rx_push) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt  <= '0;
            r_snap <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_snap) r_snap <= r_cnt;
        end
    end

    // r_io_q resets high so cpu_din reads the cleared io data byte out of reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_io_q    <= 1'b1;
            r_io_data <= '0;
            r_rd0_q   <= 1'b0;
            r_stop    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (cpu_rdy) begin
                r_io_q    <= w_io;
                r_io_data <= w_io_rdata;
            end
            r_rd0_q <= w_rd0;
            if (w_stop_wr) r_stop <= 1'b1;
            if (r_stop & w_tx_empty) r_done <= 1'b1;
        end
    end

    assign cpu_din      = r_io_q ? r_io_data : ram_din;
    assign rx_overflow  = r_ovf;
    assign program_done = r_done;

endmodule

// File: tb/tb_io_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for io_bridge: decode vector table, TX scoreboard,
// RX model queue and hand-written sequences for FIFO, counter and stop corners.
module tb_io_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        rx_overflow;
    logic        program_done;

    always #5 clk = ~clk;

    io_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk_in(clk), .rst_in(rst_n),
        .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
        .ram_a(ram_a), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .rx_overflow(rx_overflow), .program_done(program_done)
    );

    logic [7:0] ram [0:131071];
    always @(posedge clk) begin
        if (ram_we) ram[ram_a] <= ram_dout;
        ram_din <= ram[ram_a];
    end

    int checks = 0;
    int failures = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Inputs only change just after posedge, so valid&ready at negedge is the pop.
    always @(negedge clk) begin
        if (rst_n && uart_tx_valid && uart_tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected actual=%0h expected=none", uart_tx_data);
            end else begin
                check("tx_order", 32'(uart_tx_data), 32'(tx_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_a = 32'h0;
        cpu_wr = 1'b0;
        cpu_dout = 8'h00;
    endtask

    task automatic wait_rdy(input string nm);
        int n = 0;
        while (!cpu_rdy && n < 200) begin
            tick();
            n++;
        end
        if (!cpu_rdy) check({nm, "_rdy_timeout"}, 32'(cpu_rdy), 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cpu_a = a;
        cpu_wr = 1'b1;
        cpu_dout = d;
        wait_rdy("wr");
        tick();
        idle();
    endtask

    task automatic tx_write(input logic [7:0] d);
        tx_q.push_back(d);
        wr(32'h30000, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string nm);
        cpu_a = a;
        cpu_wr = 1'b0;
        wait_rdy(nm);
        tick();
        check(nm, 32'(cpu_din), 32'(exp));
        idle();
    endtask

    task automatic rx_read(input string nm);
        logic [7:0] exp;
        exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        rd(32'h30000, exp, nm);
        tick();
    endtask

    task automatic rx_inject(input logic [7:0] d);
        uart_rx_data = d;
        uart_rx_valid = 1'b1;
        if (rx_q.size() < 16) rx_q.push_back(d);
        tick();
        uart_rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tx_q.delete();
        rx_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        exp_we;
        logic [16:0] exp_ra;
        logic        chk_din;
        logic [7:0]  exp_din;
    } vec_t;
    vec_t tbl[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 32'h0000_0123, 8'hA5, 1'b1, 17'h00123, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 32'h0000_0123, 8'h00, 1'b0, 17'h00123, 1'b1, 8'hA5};
        tbl[2]  = '{1'b1, 32'h0001_FFFF, 8'h3C, 1'b1, 17'h1FFFF, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 17'h1FFFF, 1'b1, 8'h3C};
        tbl[4]  = '{1'b1, 32'h0002_0000, 8'h77, 1'b1, 17'h00000, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 17'h00000, 1'b1, 8'h77};
        tbl[6]  = '{1'b1, 32'hFFF0_0456, 8'h5A, 1'b1, 17'h00456, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 32'h0000_0456, 8'h00, 1'b0, 17'h00456, 1'b1, 8'h5A};
        tbl[8]  = '{1'b1, 32'h0003_0002, 8'h11, 1'b0, 17'h10002, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 32'h0003_0001, 8'h00, 1'b0, 17'h10001, 1'b1, 8'h00};
        tbl[10] = '{1'b0, 32'h0003_8000, 8'h00, 1'b0, 17'h18000, 1'b1, 8'h00};
        tbl[11] = '{1'b0, 32'h0003_0003, 8'h00, 1'b0, 17'h10003, 1'b1, 8'h00};
        tbl[12] = '{1'b1, 32'h0003_0008, 8'h99, 1'b0, 17'h10008, 1'b0, 8'h00};
        tbl[13] = '{1'b0, 32'h0001_0002, 8'h00, 1'b0, 17'h10002, 1'b1, 8'h00};

        for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
        uart_tx_ready = 1'b0;
        uart_rx_data = 8'h00;
        uart_rx_valid = 1'b0;
        idle();
        rst_n = 1'b0;
        #3;
        check("rst_din", 32'(cpu_din), 32'h0);
        check("rst_rdy", 32'(cpu_rdy), 32'h1);
        check("rst_txv", 32'(uart_tx_valid), 32'h0);
        check("rst_ovf", 32'(rx_overflow), 32'h0);
        check("rst_done", 32'(program_done), 32'h0);
        do_reset();

        // Decode / RAM path table
        for (int i = 0; i < 14; i++) begin
            cpu_a = tbl[i].a;
            cpu_wr = tbl[i].wr;
            cpu_dout = tbl[i].d;
            #1;
            check($sformatf("vec%0d_we", i), 32'(ram_we), 32'(tbl[i].exp_we));
            check($sformatf("vec%0d_ra", i), 32'(ram_a), 32'(tbl[i].exp_ra));
            if (tbl[i].wr) check($sformatf("vec%0d_rd", i), 32'(ram_dout), 32'(tbl[i].d));
            tick();
            if (tbl[i].chk_din) check($sformatf("vec%0d_din", i), 32'(cpu_din), 32'(tbl[i].exp_din));
        end
        idle();

        // TX: zero bytes are never queued
        do_reset();
        uart_tx_ready = 1'b1;
        tx_write(8'h48);
        wr(32'h30000, 8'h00);
        tx_write(8'h69);
        repeat (4) tick();
        check("tx_hi_drain", 32'(tx_q.size()), 32'd0);
        check("tx_hi_empty", 32'(uart_tx_valid), 32'd0);

        // TX full stall and release by a single pop
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tx_write(8'h80 + 8'(i));
            if (i == 14) check("tx_rdy_at15", 32'(cpu_rdy), 32'd1);
        end
        check("tx_full_rdy", 32'(cpu_rdy), 32'd0);
        cpu_a = 32'h30000;
        cpu_wr = 1'b1;
        cpu_dout = 8'h90;
        tx_q.push_back(8'h90);
        repeat (3) tick();
        check("tx_stall_hold", 32'(cpu_rdy), 32'd0);
        uart_tx_ready = 1'b1;
        tick();
        uart_tx_ready = 1'b0;
        check("tx_rdy_after_pop", 32'(cpu_rdy), 32'd1);
        tick();
        idle();
        check("tx_refull", 32'(cpu_rdy), 32'd0);
        uart_tx_ready = 1'b1;
        for (int n = 0; n < 100 && tx_q.size() != 0; n++) tick();
        tick();
        check("tx_full_drain", 32'(tx_q.size()), 32'd0);
        check("tx_full_empty", 32'(uart_tx_valid), 32'd0);

        // RX: held read pops once per run
        do_reset();
        rx_inject(8'h31);
        rx_inject(8'h32);
        cpu_a = 32'h30000;
        cpu_wr = 1'b0;
        tick();
        check("rx_hold_first", 32'(cpu_din), 32'(rx_q.pop_front()));
        tick();
        tick();
        idle();
        tick();
        rx_read("rx_second");
        rx_read("rx_empty");

        // RX overflow
        do_reset();
        for (int i = 0; i < 17; i++) begin
            rx_inject(8'h40 + 8'(i));
            if (i == 15) check("rx_ovf_at16", 32'(rx_overflow), 32'd0);
        end
        check("rx_ovf_at17", 32'(rx_overflow), 32'd1);
        for (int i = 0; i < 16; i++) rx_read($sformatf("rx_ovf_data%0d", i));
        rx_read("rx_ovf_empty");
        check("rx_ovf_sticky", 32'(rx_overflow), 32'd1);

        // Asynchronous reset mid-operation discards queued TX data
        uart_tx_ready = 1'b0;
        tx_write(8'hC1);
        tx_write(8'hC2);
        rx_inject(8'hD1);
        rst_n = 1'b0;
        #2;
        check("arst_txv", 32'(uart_tx_valid), 32'd0);
        check("arst_ovf", 32'(rx_overflow), 32'd0);
        check("arst_rdy", 32'(cpu_rdy), 32'd1);
        do_reset();
        rx_read("arst_rx_empty");

        // RX full with same-cycle pop accepts the push
        do_reset();
        for (int i = 0; i < 16; i++) rx_inject(8'h60 + 8'(i));
        cpu_a = 32'h30000;
        cpu_wr = 1'b0;
        uart_rx_data = 8'h70;
        uart_rx_valid = 1'b1;
        tick();
        uart_rx_valid = 1'b0;
        check("rx_fullpop_data", 32'(cpu_din), 32'(rx_q.pop_front()));
        rx_q.push_back(8'h70);
        idle();
        tick();
        check("rx_fullpop_ovf", 32'(rx_overflow), 32'd0);
        for (int i = 0; i < 16; i++) rx_read($sformatf("rx_fullpop%0d", i));

        // Counter start, increment, snapshot across wrap
        do_reset();
        rd(32'h30004, 8'h00, "cnt_start");
        rd(32'h30005, 8'h00, "cnt_snap1");
        rd(32'h30004, 8'h02, "cnt_incr");
        cpu_a = 32'h30004;
        cpu_wr = 1'b0;
        force dut.r_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_cnt;
        tick();
        check("wrap_b0", 32'(cpu_din), 32'hFE);
        rd(32'h30005, 8'hFF, "wrap_b1");
        rd(32'h30006, 8'hFF, "wrap_b2");
        rd(32'h30007, 8'hFF, "wrap_b3");
        rd(32'h30004, 8'h02, "wrap_new_b0");
        rd(32'h30007, 8'h00, "wrap_new_b3");

        // program_done waits for the TX drain
        do_reset();
        uart_tx_ready = 1'b0;
        tx_write(8'hA1);
        tx_write(8'hA2);
        tx_write(8'hA3);
        wr(32'h30004, 8'h00);
        repeat (3) tick();
        check("done_pending", 32'(program_done), 32'd0);
        uart_tx_ready = 1'b1;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 50 && !seen; k++) begin
                tick();
                if (!uart_tx_valid) begin
                    seen = 1'b1;
                    check("done_at_drain", 32'(program_done), 32'd0);
                    tick();
                    check("done_after_drain", 32'(program_done), 32'd1);
                end
            end
            if (!seen) check("done_drain_timeout", 32'(uart_tx_valid), 32'd0);
        end
        check("done_txq", 32'(tx_q.size()), 32'd0);
        tx_write(8'hB1);
        repeat (3) tick();
        check("done_hold", 32'(program_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Sits directly downstream of the CPU core's byte memory bus (address, write enable, data out/in, rdy).
- Routes RAM accesses straight through to the 128 KB block RAM.
- Terminates the memory-mapped I/O region at 0x30000–0x30007: UART TX/RX byte FIFOs, a free-running cycle counter, and the program-stop flag.
- Drives the core's rdy input to stall the core while the TX FIFO is full.

Parameters:
- TX_DEPTH, 16: TX FIFO entries; must be a power of 2, ≥ 2.
- RX_DEPTH, 16: RX FIFO entries; must be a power of 2, ≥ 2.

Ports:
- clk_in  in  1  single system clock; all state on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- cpu_a  in  32  core address; only bits [17:0] are decoded.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_dout  in  8  write data from core.
- cpu_din  out  8  read data to core, valid the cycle after the address.
- cpu_rdy  out  1  to core rdy_in; 0 pauses the core.
- ram_a  out  17  RAM address.
- ram_we  out  1  RAM write enable.
- ram_dout  out  8  RAM write data.
- ram_din  in  8  RAM read data, registered inside the RAM with 1-cycle latency.
- uart_tx_data  out  8  TX byte (FIFO head).
- uart_tx_valid  out  1  TX FIFO not empty.
- uart_tx_ready  in  1  UART accepts the head byte this cycle.
- uart_rx_data  in  8  received byte.
- uart_rx_valid  in  1  1-cycle strobe; rx byte valid.
- rx_overflow  out  1  sticky flag; an RX byte was dropped.
- program_done  out  1  sticky flag; stop requested and TX drained.

Behaviour:
- Reset (rst_in = 0, asynchronous):
  - Both FIFOs empty; counter = 0.
  - cpu_din = 0, rx_overflow = 0, program_done = 0, stop_req = 0, uart_tx_valid = 0.
  - cpu_rdy = 1.
  - Reset mid-operation discards all FIFO contents.
- Decode:
  - io = (cpu_a[17:16] == 2'b11); otherwise RAM.
  - ram_a = cpu_a[16:0] and ram_dout = cpu_dout, combinational.
  - ram_we = cpu_wr & ~io & cpu_rdy.
- Access qualifier: an access counts only in cycles where cpu_rdy = 1.
- Read latency: 1 cycle.
  - A registered select (io_q, io data byte) is captured at the address cycle.
  - Next cycle: cpu_din = ram_din if ~io_q, else the io data register.
- cpu_rdy:
  - cpu_rdy = ~tx_full, where tx_full comes from the registered count.
  - While cpu_rdy = 0, no access of any kind is performed.
- 0x30000 write: pushes cpu_dout into the TX FIFO if cpu_dout != 0x00; a write of 0x00 is ignored.
- TX pop:
  - Pops when uart_tx_valid & uart_tx_ready.
  - Push and pop in the same cycle leaves the count unchanged.
  - A pop while full raises cpu_rdy on the next cycle.
- 0x30000 read:
  - Pops one RX byte only on the first cycle of a run of consecutive qualified reads to 0x30000. Edge detect uses a registered "previous cycle was a qualified read of 0x30000" bit, so a held address pops exactly once.
  - Returns the popped byte; returns 0x00 if RX is empty, with no pop.
- RX push:
  - Pushes on uart_rx_valid.
  - When full, the incoming byte is dropped and rx_overflow is set.
  - When full and a pop occurs in the same cycle, the push is accepted and there is no overflow.
  - rx_overflow clears only on reset.
- Cycle counter:
  - 32-bit; increments every cycle after reset, including while cpu_rdy = 0.
  - Wraps from 0xFFFFFFFF to 0.
  - A read of 0x30004 snapshots the counter and returns byte 0.
  - Reads of 0x30005–0x30007 return snapshot bytes 1–3 without re-snapshotting, so the 4-byte word is consistent.
- 0x30004 write:
  - Sets stop_req (any data value).
  - program_done is set the first cycle stop_req = 1 and the TX FIFO is empty, then holds until reset.
- Other I/O addresses: reads return 0x00; writes are ignored.
- FIFO implementation: circular buffers with log2(DEPTH)+1-bit pointers; full/empty are derived from the MSB difference; wrap-around is seamless.

Test Plan:
- Reset, then RAM write 0xA5 @0x00123 followed by a read of 0x00123 → ram_we pulses once; cpu_din = 0xA5 one cycle after the read address.
- Writes of 'H', 0x00, 'i' to 0x30000 with uart_tx_ready = 1 → uart_tx_data emits 0x48 then 0x69 only; 0x00 is never queued.
- uart_tx_ready = 0 and 17 non-zero writes with TX_DEPTH = 16 → cpu_rdy = 0 after the 16th push; the 17th byte is accepted after one pop; byte order is preserved.
- Inject 0x31, 0x32; hold a read of 0x30000 for 3 cycles, release, read again → returns 0x31 then 0x32, one pop per run; a third read on empty returns 0x00.
- 17 uart_rx_valid strobes with no reads → rx_overflow = 1; FIFO holds the first 16 bytes.
- Counter forced near 0xFFFFFFFE, reads of 0x30004–0x30007 across the wrap → bytes come from a single snapshot. Then write 0x30004 with 3 TX bytes queued → program_done rises only after the last TX pop.
